// File: rtl/controlador_matriz_leds_pkg.sv
// Shared constants and types for the LED matrix display path.
// Latency: none (package only).
// Backpressure: none (package only).
package controlador_matriz_leds_pkg;

    localparam int             NUM_COLUNAS = 5;
    localparam int             NUM_LINHAS  = 7;
    localparam int             COL_BITS    = 3;
    localparam logic [4:0]     COLUNAS_OFF = 5'b11111;

    typedef logic [NUM_COLUNAS-1:0] coluna_t;
    typedef logic [NUM_LINHAS-1:0]  linha_t;
    typedef logic [COL_BITS-1:0]    coord_t;

    // Single-bit row mask for the blinking cursor; zero whenever the cursor
    // is out of range, not on the scanned column, or in its dark half-period.
    function automatic linha_t cursor_mask(input coord_t col_idx,
                                           input coord_t coord_col,
                                           input coord_t coord_lin,
                                           input logic   blink_phase);
        linha_t m;
        m = '0;
        if (blink_phase && (col_idx == coord_col) &&
            (coord_col <= coord_t'(NUM_COLUNAS - 1)) &&
            (coord_lin <= coord_t'(NUM_LINHAS - 1))) begin
            m[coord_lin] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/controlador_matriz_leds_if.sv
// Bundles the hit map, cursor coordinates and matrix drive of the display stage.
// Latency: none (wires only).
// Backpressure: none; the display consumes its inputs continuously.
interface controlador_matriz_leds_if;
    import controlador_matriz_leds_pkg::*;

    logic   enable;
    linha_t matriz0;
    linha_t matriz1;
    linha_t matriz2;
    linha_t matriz3;
    linha_t matriz4;
    coord_t coordColuna;
    coord_t coordLinha;
    coluna_t colunas;
    linha_t  linhas;
    logic    frame_tick;

    // master: upstream producer (attack manager / bench); slave: the display.
    modport master (output enable, matriz0, matriz1, matriz2, matriz3, matriz4,
                           coordColuna, coordLinha,
                    input  colunas, linhas, frame_tick);
    modport slave  (input  enable, matriz0, matriz1, matriz2, matriz3, matriz4,
                           coordColuna, coordLinha,
                    output colunas, linhas, frame_tick);
endinterface

// File: rtl/controlador_matriz_leds_divisor_varredura.sv
// Column scan timer: divider per column slot plus 0..4 column counter.
// Latency: strobes are combinational from the registered counters.
// Backpressure: none; enable low clears and holds the counters at zero.
module controlador_matriz_leds_divisor_varredura
    import controlador_matriz_leds_pkg::*;
#(
    parameter int DIV_COLUNA = 1000
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   enable,
    output logic   slot_blank,   // divider at 0: anti-ghosting cycle
    output coord_t col_idx,
    output logic   frame_wrap    // last cycle of column 4 while enabled
);
    localparam int           DW       = (DIV_COLUNA > 1) ? $clog2(DIV_COLUNA) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COLUNA - 1);
    localparam coord_t        COL_LAST = coord_t'(NUM_COLUNAS - 1);

    logic [DW-1:0] div_q, div_d;
    coord_t        col_q, col_d;

    always_comb begin
        div_d = div_q;
        col_d = col_q;
        if (!enable) begin
            div_d = '0;
            col_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            col_d = (col_q == COL_LAST) ? '0 : col_q + coord_t'(1);
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            col_q <= '0;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
        end
    end

    assign slot_blank = (div_q == '0);
    assign col_idx    = col_q;
    assign frame_wrap = enable && (div_q == DIV_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/controlador_matriz_leds.sv
// Scans the 5x7 hit map onto the LED matrix one column at a time with a blinking cursor.
// Latency: one clock from state/inputs to the registered colunas/linhas/frame_tick.
// Backpressure: none; enable low blanks the matrix and restarts scan and blink timing.
module controlador_matriz_leds
    import controlador_matriz_leds_pkg::*;
#(
    parameter int DIV_COLUNA   = 1000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                        clock,
    input  logic                        reset,
    controlador_matriz_leds_if.slave    bus
);
    localparam int            FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FC_LAST = FW'(BLINK_FRAMES - 1);

    logic   slot_blank;
    coord_t col_idx;
    logic   frame_wrap;

    controlador_matriz_leds_divisor_varredura #(
        .DIV_COLUNA (DIV_COLUNA)
    ) u_divisor_varredura (
        .clock      (clock),
        .reset      (reset),
        .enable     (bus.enable),
        .slot_blank (slot_blank),
        .col_idx    (col_idx),
        .frame_wrap (frame_wrap)
    );

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    coluna_t       colunas_q, colunas_d;
    linha_t        linhas_q, linhas_d;
    logic          frame_tick_q, frame_tick_d;
    linha_t        matriz_sel;

    always_comb begin
        case (col_idx)
            3'd0:    matriz_sel = bus.matriz0;
            3'd1:    matriz_sel = bus.matriz1;
            3'd2:    matriz_sel = bus.matriz2;
            3'd3:    matriz_sel = bus.matriz3;
            3'd4:    matriz_sel = bus.matriz4;
            default: matriz_sel = '0;
        endcase
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        colunas_d     = COLUNAS_OFF;
        linhas_d      = '0;
        frame_tick_d  = frame_wrap;

        if (!bus.enable) begin
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        // XOR overlay: a lit hit blinks off, a dark cell blinks on.
        if (bus.enable && !slot_blank) begin
            colunas_d = ~(coluna_t'(1) << col_idx);
            linhas_d  = matriz_sel ^ cursor_mask(col_idx, bus.coordColuna,
                                                 bus.coordLinha, blink_phase_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            colunas_q     <= COLUNAS_OFF;
            linhas_q      <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            colunas_q     <= colunas_d;
            linhas_q      <= linhas_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign bus.colunas    = colunas_q;
    assign bus.linhas     = linhas_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
